image_hfilter3: RTL and testbench

//  Horizontal 3-tap [1 2 1]/4 smoothing stage. It sits directly downstream of image_pipe
//  and consumes its im_* stream on its is_* port. It emits the filtered pixel stream with the

---
 rtl/image_pipe_pkg.sv | 33 +++
 rtl/image_skid_fifo.sv | 72 +++++++
 rtl/image_hfilter3.sv | 176 +++++++++++++++++
 tb/tb_image_hfilter3.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_pipe_pkg.sv
// ============================================================================
//  image_pipe_pkg : shared types and helpers for the image_pipe filter stages
//  Rev 1.0
// ============================================================================
`default_nettype none

package image_pipe_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        END   = 3'd4
    } hf_state_t;

    localparam int ROUND  = 2;
    localparam int MAX_DW = 64;

    // [1 2 1]/4 with round-half-up; two guard bits keep the sum exact for any DW <= MAX_DW
    function automatic logic [MAX_DW-1:0] f121(
        input logic [MAX_DW-1:0] p0,
        input logic [MAX_DW-1:0] p1,
        input logic [MAX_DW-1:0] p2
    );
        logic [MAX_DW+1:0] sum;
        sum = {2'b00, p0} + {1'b0, p1, 1'b0} + {2'b00, p2} + (MAX_DW+2)'(ROUND);
        return MAX_DW'(sum >> 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/image_skid_fifo.sv
// ============================================================================
//  image_skid_fifo : synchronous show-ahead FIFO with occupancy count
//  Rev 1.0
// ============================================================================
`default_nettype none

module image_skid_fifo #(
    parameter int DW     = 32,
    parameter int FIFO_D = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [DW-1:0]             wdata_i,
    input  logic                      pop_i,
    output logic [DW-1:0]             rdata_o,
    output logic [$clog2(FIFO_D):0]   count_o,
    output logic                      ovf_o
);

    localparam int AW = $clog2(FIFO_D);
    localparam logic [AW:0] c_full = (AW+1)'(FIFO_D);

    logic [DW-1:0] mem_q [FIFO_D];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          w_push_ok;
    logic          w_pop_ok;

    // A write into a full FIFO is dropped and flagged; it never corrupts stored data
    assign w_push_ok = push_i && (count_q != c_full);
    assign w_pop_ok  = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_i && !w_push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/image_hfilter3.sv
// ============================================================================
//  image_hfilter3 : horizontal [1 2 1]/4 smoother with replicate edge padding
//  Rev 1.0
// ============================================================================
`default_nettype none

module image_hfilter3
    import image_pipe_pkg::*;
#(
    parameter int DW     = 32,
    parameter int LINE_W = 640,
    parameter int FIFO_D = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] is_data_in,
    input  logic          is_valid_in,
    input  logic          is_end_in,
    output logic          is_busy_out,
    output logic [DW-1:0] im_data_out,
    output logic          im_valid_out,
    output logic          im_end_out,
    input  logic          im_busy_in
);

    localparam int CW = $clog2(LINE_W);
    localparam int NW = $clog2(FIFO_D) + 1;
    localparam logic [CW-1:0] c_col_last = CW'(LINE_W - 1);
    localparam logic [NW-1:0] c_busy_th  = NW'(FIFO_D - 2);

    hf_state_t     state_q, state_d;
    logic [DW-1:0] p0_q, p0_d, p1_q, p1_d;
    logic [CW-1:0] col_q, col_d;
    logic          end_pend_q, end_pend_d;
    logic [DW-1:0] im_data_q, im_data_d;
    logic          im_valid_q, im_valid_d;
    logic          im_end_q, im_end_d;
    logic          busy_q;

    logic [DW-1:0] w_rdata;
    logic [NW-1:0] w_count;
    logic          w_empty;
    logic          w_adv;
    logic          w_pop;
    logic [DW-1:0] w_p2;
    logic [DW-1:0] w_filt;
    logic          ovf_err;

    image_skid_fifo #(
        .DW     (DW),
        .FIFO_D (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (is_valid_in),
        .wdata_i (is_data_in),
        .pop_i   (w_pop),
        .rdata_o (w_rdata),
        .count_o (w_count),
        .ovf_o   (ovf_err)
    );

    assign w_empty = (w_count == '0);
    assign w_adv   = !im_busy_in;
    // FLUSH replicates the right-edge pixel instead of reading a new one
    assign w_p2    = (state_q == FLUSH) ? p1_q : w_rdata;
    assign w_filt  = DW'(f121(MAX_DW'(p0_q), MAX_DW'(p1_q), MAX_DW'(w_p2)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_adv) begin
            case (state_q)
                IDLE: begin
                    if (!w_empty)        state_d = FILL;
                    else if (end_pend_q) state_d = END;
                end
                FILL, RUN: begin
                    if (!w_empty)        state_d = (col_q == c_col_last) ? FLUSH : RUN;
                    else if (end_pend_q) state_d = FLUSH;
                end
                FLUSH:   state_d = (end_pend_q && w_empty) ? END : IDLE;
                END:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        w_pop      = 1'b0;
        p0_d       = p0_q;
        p1_d       = p1_q;
        col_d      = col_q;
        end_pend_d = end_pend_q;
        im_data_d  = im_data_q;
        im_valid_d = im_valid_q;
        im_end_d   = im_end_q;
        if (w_adv) begin
            im_data_d  = '0;
            im_valid_d = 1'b0;
            im_end_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        p0_d  = w_rdata;
                        p1_d  = w_rdata;
                        col_d = CW'(1);
                    end
                end
                FILL, RUN: begin
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        im_data_d  = w_filt;
                        im_valid_d = 1'b1;
                        p0_d       = p1_q;
                        p1_d       = w_rdata;
                        if (col_q != c_col_last) begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    im_data_d  = w_filt;
                    im_valid_d = 1'b1;
                    col_d      = '0;
                end
                END: begin
                    im_end_d   = 1'b1;
                    end_pend_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (is_end_in) begin
            end_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_q       <= '0;
            p1_q       <= '0;
            col_q      <= '0;
            end_pend_q <= 1'b0;
            im_data_q  <= '0;
            im_valid_q <= 1'b0;
            im_end_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            col_q      <= col_d;
            end_pend_q <= end_pend_d;
            im_data_q  <= im_data_d;
            im_valid_q <= im_valid_d;
            im_end_q   <= im_end_d;
            busy_q     <= (w_count >= c_busy_th);
        end
    end

    assign is_busy_out  = busy_q;
    assign im_data_out  = im_data_q;
    assign im_valid_out = im_valid_q;
    assign im_end_out   = im_end_q;

endmodule

`default_nettype wire

// File: tb/tb_image_hfilter3.sv
// ============================================================================
//  tb_image_hfilter3 : directed self-checking bench for image_hfilter3
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_image_hfilter3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        vin, ein, busy_in;

    logic        a_busy, a_valid, a_end;
    logic [31:0] a_data;
    logic        b_busy, b_valid, b_end;
    logic [31:0] b_data;
    logic        c_busy, c_valid, c_end;
    logic [7:0]  c_data;

    always #5 clk = ~clk;

    image_hfilter3 #(.DW(32), .LINE_W(4), .FIFO_D(4)) u_a (
        .clk(clk), .rst_n(rst_n), .is_data_in(din), .is_valid_in(vin), .is_end_in(ein),
        .is_busy_out(a_busy), .im_data_out(a_data), .im_valid_out(a_valid),
        .im_end_out(a_end), .im_busy_in(busy_in)
    );

    image_hfilter3 #(.DW(32), .LINE_W(8), .FIFO_D(4)) u_b (
        .clk(clk), .rst_n(rst_n), .is_data_in(din), .is_valid_in(vin), .is_end_in(ein),
        .is_busy_out(b_busy), .im_data_out(b_data), .im_valid_out(b_valid),
        .im_end_out(b_end), .im_busy_in(busy_in)
    );

    image_hfilter3 #(.DW(8), .LINE_W(4), .FIFO_D(4)) u_c (
        .clk(clk), .rst_n(rst_n), .is_data_in(din[7:0]), .is_valid_in(vin), .is_end_in(ein),
        .is_busy_out(c_busy), .im_data_out(c_data), .im_valid_out(c_valid),
        .im_end_out(c_end), .im_busy_in(busy_in)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] qa[$], qb[$], qc[$];
    int          ea, eb, ec, eb_pos;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] ref121(input logic [31:0] l, input logic [31:0] c,
                                           input logic [31:0] r);
        longint s;
        s = (longint'(l) + 2 * longint'(c) + longint'(r) + 2) / 4;
        return 32'(s);
    endfunction

    // Logs every output beat accepted by downstream, then advances one clock
    task automatic tick();
        if (a_valid === 1'b1 && !busy_in) qa.push_back(a_data);
        if (b_valid === 1'b1 && !busy_in) qb.push_back(b_data);
        if (c_valid === 1'b1 && !busy_in) qc.push_back({24'd0, c_data});
        if (a_end === 1'b1 && !busy_in) ea++;
        if (b_end === 1'b1 && !busy_in) begin
            eb++;
            eb_pos = qb.size();
        end
        if (c_end === 1'b1 && !busy_in) ec++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        qa.delete(); qb.delete(); qc.delete();
        ea = 0; eb = 0; ec = 0; eb_pos = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vin = 1'b0; ein = 1'b0; busy_in = 1'b0; din = '0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic push(input logic [31:0] v, input logic e);
        for (int g = 0; g < 20 && (a_busy || b_busy || c_busy); g++) begin
            vin = 1'b0;
            tick();
        end
        din = v; vin = 1'b1; ein = e;
        tick();
        vin = 1'b0; ein = 1'b0;
    endtask

    task automatic idle(input int n);
        vin = 1'b0; ein = 1'b0;
        repeat (n) tick();
    endtask

    logic [31:0] exp_t1 [4] = '{32'd5, 32'd8, 32'd12, 32'd15};
    logic [31:0] exp_t4 [8] = '{32'd5, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd31};
    logic [31:0] exp_t5 [8] = '{32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hBF, 32'h80, 32'hBF, 32'hFF};
    logic [31:0] pix3 [16];
    logic [31:0] hold_d;
    logic        hold_v;
    logic        saw_busy;
    int          idx;
    int          bad;

    initial begin
        // reset state and single line
        do_reset();
        check("reset_valid", 32'(a_valid), 32'd0);
        check("reset_data", a_data, 32'd0);
        check("reset_end", 32'(a_end), 32'd0);
        check("reset_busy", 32'(a_busy), 32'd0);
        check("reset_ovf", 32'(u_a.ovf_err), 32'd0);
        push(32'd4, 1'b0); push(32'd8, 1'b0); push(32'd12, 1'b0); push(32'd16, 1'b0);
        idle(10);
        check("t1_count", 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t1_pix", qget(qa, i), exp_t1[i]);
        check("t1_no_end", 32'(ea), 32'd0);

        // three constant lines, end flagged with the last pixel
        do_reset();
        for (int i = 0; i < 23; i++) push(32'd100, 1'b0);
        push(32'd100, 1'b1);
        idle(30);
        check("t2_count", 32'(qb.size()), 32'd24);
        bad = 0;
        foreach (qb[i]) if (qb[i] !== 32'd100) bad++;
        check("t2_all_100", 32'(bad), 32'd0);
        check("t2_end_count", 32'(eb), 32'd1);
        check("t2_end_pos", 32'(eb_pos), 32'd24);
        check("t2_ovf", 32'(u_b.ovf_err), 32'd0);

        // downstream stall while upstream keeps streaming
        do_reset();
        for (int i = 0; i < 16; i++) pix3[i] = 32'(5 * i * i + 3 * i + 2);
        idx = 0;
        saw_busy = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            busy_in = (cyc >= 5 && cyc < 15);
            if (idx < 16 && !(a_busy || b_busy || c_busy)) begin
                din = pix3[idx]; vin = 1'b1; idx++;
            end else begin
                vin = 1'b0;
            end
            if (a_busy) saw_busy = 1'b1;
            hold_d = a_data;
            hold_v = a_valid;
            tick();
            if (busy_in) begin
                check("t3_hold_data", a_data, hold_d);
                check("t3_hold_valid", 32'(a_valid), 32'(hold_v));
            end
        end
        vin = 1'b0;
        busy_in = 1'b0;
        idle(10);
        check("t3_busy_seen", 32'(saw_busy), 32'd1);
        check("t3_all_sent", 32'(idx), 32'd16);
        check("t3_ovf", 32'(u_a.ovf_err), 32'd0);
        check("t3_count", 32'(qa.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            int x;
            x = i % 4;
            check("t3_pix", qget(qa, i),
                  ref121((x == 0) ? pix3[i] : pix3[i-1], pix3[i],
                         (x == 3) ? pix3[i] : pix3[i+1]));
        end

        // partial line then a fresh frame
        do_reset();
        push(32'd1, 1'b0); push(32'd2, 1'b0); push(32'd3, 1'b0);
        vin = 1'b0; ein = 1'b1;
        tick();
        ein = 1'b0;
        idle(15);
        check("t4_end_count", 32'(eb), 32'd1);
        check("t4_end_pos", 32'(eb_pos), 32'd3);
        check("t4_pix0", qget(qb, 0), 32'd1);
        check("t4_pix1", qget(qb, 1), 32'd2);
        check("t4_pix2", qget(qb, 2), 32'd3);
        for (int i = 0; i < 8; i++) push(32'(4 * (i + 1)), 1'b0);
        idle(20);
        check("t4_count", 32'(qb.size()), 32'd11);
        for (int i = 0; i < 8; i++) check("t4_next_frame", qget(qb, 3 + i), exp_t4[i]);

        // 8-bit datapath at full scale
        do_reset();
        for (int i = 0; i < 4; i++) push(32'hFF, 1'b0);
        push(32'hFF, 1'b0); push(32'h00, 1'b0); push(32'hFF, 1'b0); push(32'hFF, 1'b0);
        idle(12);
        check("t5_count", 32'(qc.size()), 32'd8);
        for (int i = 0; i < 8; i++) check("t5_pix", qget(qc, i), exp_t5[i]);

        // one-cycle reset mid-line
        do_reset();
        push(32'd4, 1'b0); push(32'd8, 1'b0); push(32'd12, 1'b0);
        check("t6_pre_valid", 32'(a_valid), 32'd1);
        check("t6_pre_data", a_data, 32'd5);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", 32'(a_valid), 32'd0);
        check("t6_rst_data", a_data, 32'd0);
        check("t6_rst_end", 32'(a_end), 32'd0);
        check("t6_rst_busy", 32'(a_busy), 32'd0);
        rst_n = 1'b1;
        clear_log();
        push(32'd4, 1'b0); push(32'd8, 1'b0); push(32'd12, 1'b0); push(32'd16, 1'b0);
        idle(10);
        check("t6_count", 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t6_pix", qget(qa, i), exp_t1[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
